// File: rtl/param_reservation_station.sv
// Tomasulo-style reservation station with CDB snoop, dispatch bypass and oldest-first issue.
// Issue outputs are combinational from registered entries only; dispatch is accepted while any entry is free.
module param_reservation_station #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int OP_W       = 2,
  parameter int IDX_W      = 2,
  parameter int ID_W       = 2,
  parameter int STATION_ID = 1,
  localparam int LW        = ID_W + IDX_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic [LW-1:0]     disp_q1,
  input  logic [LW-1:0]     disp_q2,
  output logic              disp_ready,
  output logic [LW-1:0]     disp_label,
  input  logic              bc_valid,
  input  logic [LW-1:0]     bc_label,
  input  logic [DATA_W-1:0] bc_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_v1,
  output logic [DATA_W-1:0] iss_v2,
  output logic [LW-1:0]     iss_label,
  output logic [IDX_W:0]    count
);

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [DATA_W-1:0] vj   [DEPTH];
  logic [DATA_W-1:0] vk   [DEPTH];
  logic [LW-1:0]     qj   [DEPTH];
  logic [LW-1:0]     qk   [DEPTH];
  logic [IDX_W-1:0]  rank [DEPTH];

  logic [DEPTH-1:0]  rdy;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  sel_rank;
  logic              bc_hit;
  logic              do_disp;
  logic              do_iss;
  logic [IDX_W-1:0]  new_rank;

  assign disp_ready = |(~busy);
  assign disp_label = {ID_W'(STATION_ID), free_idx};
  assign bc_hit     = bc_valid && (bc_label != '0);
  assign do_disp    = disp_valid && disp_ready && !flush;
  assign do_iss     = sel_found && iss_ready && !flush;
  // Rank of a new entry counts survivors of this edge's issue, so it is always the youngest.
  assign new_rank   = IDX_W'(count - (IDX_W+1)'(do_iss));

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    rdy       = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = busy[i] && (qj[i] == '0) && (qk[i] == '0);
      if (rdy[i] && (!sel_found || rank[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank[i];
      end
    end
  end

  assign iss_valid = sel_found;
  assign iss_op    = sel_found ? op_q[sel_idx] : '0;
  assign iss_v1    = sel_found ? vj[sel_idx]   : '0;
  assign iss_v2    = sel_found ? vk[sel_idx]   : '0;
  assign iss_label = sel_found ? {ID_W'(STATION_ID), sel_idx} : '0;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      busy  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        vj[i]   <= '0;
        vk[i]   <= '0;
        qj[i]   <= '0;
        qk[i]   <= '0;
        rank[i] <= '0;
      end
    end else if (flush) begin
      busy  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qj[i]   <= '0;
        qk[i]   <= '0;
        rank[i] <= '0;
      end
    end else begin
      count <= count + (IDX_W+1)'(do_disp) - (IDX_W+1)'(do_iss);
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && bc_hit && qj[i] == bc_label) begin
          vj[i] <= bc_data;
          qj[i] <= '0;
        end
        if (busy[i] && bc_hit && qk[i] == bc_label) begin
          vk[i] <= bc_data;
          qk[i] <= '0;
        end
        if (do_iss && sel_idx == IDX_W'(i)) begin
          busy[i] <= 1'b0;
          rank[i] <= '0;
        end else if (do_iss && busy[i] && rank[i] > sel_rank) begin
          rank[i] <= rank[i] - 1'b1;
        end
      end
      // free_idx is never busy, so this write cannot collide with the snoop or issue above.
      if (do_disp) begin
        busy[free_idx] <= 1'b1;
        op_q[free_idx] <= disp_op;
        rank[free_idx] <= new_rank;
        if (bc_hit && disp_q1 == bc_label) begin
          vj[free_idx] <= bc_data;
          qj[free_idx] <= '0;
        end else begin
          vj[free_idx] <= disp_v1;
          qj[free_idx] <= disp_q1;
        end
        if (bc_hit && disp_q2 == bc_label) begin
          vk[free_idx] <= bc_data;
          qk[free_idx] <= '0;
        end else begin
          vk[free_idx] <= disp_v2;
          qk[free_idx] <= disp_q2;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_reservation_station.sv
// Directed vector table for param_reservation_station (defaults: 4 entries, station 1) plus an async-reset sequence.
module tb_param_reservation_station;

  logic        clk = 1'b0;
  logic        RST;
  logic        flush;
  logic        disp_valid;
  logic [1:0]  disp_op;
  logic [31:0] disp_v1, disp_v2;
  logic [3:0]  disp_q1, disp_q2;
  logic        disp_ready;
  logic [3:0]  disp_label;
  logic        bc_valid;
  logic [3:0]  bc_label;
  logic [31:0] bc_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_op;
  logic [31:0] iss_v1, iss_v2;
  logic [3:0]  iss_label;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  param_reservation_station dut (
    .clk(clk), .RST(RST), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_ready(disp_ready), .disp_label(disp_label),
    .bc_valid(bc_valid), .bc_label(bc_label), .bc_data(bc_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_label(iss_label), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [1:0]  op;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic        bv;
    logic [3:0]  bl;
    logic [31:0] bd;
    logic        ir, fl;
    logic [2:0]  e_cnt;
    logic        e_dr;
    logic [3:0]  e_dl;
    logic        e_iv;
    logic [3:0]  e_il;
    logic [1:0]  e_op;
    logic [31:0] e_v1, e_v2;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(int dv, int op, int v1, int v2, int q1, int q2, int bv, int bl, int bd,
                              int ir, int fl, int cnt, int dr, int dl, int iv, int il, int eop,
                              int ev1, int ev2);
    vec_t r;
    r.dv = dv[0];     r.op = op[1:0];   r.v1 = v1;        r.v2 = v2;
    r.q1 = q1[3:0];   r.q2 = q2[3:0];   r.bv = bv[0];     r.bl = bl[3:0];
    r.bd = bd;        r.ir = ir[0];     r.fl = fl[0];     r.e_cnt = cnt[2:0];
    r.e_dr = dr[0];   r.e_dl = dl[3:0]; r.e_iv = iv[0];   r.e_il = il[3:0];
    r.e_op = eop[1:0]; r.e_v1 = ev1;    r.e_v2 = ev2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int cnt, input int dr, input int dl, input int iv,
                          input int il, input int eop, input int ev1, input int ev2);
    chk({tag, "_count"},      32'(count),      32'(cnt));
    chk({tag, "_disp_ready"}, 32'(disp_ready), 32'(dr));
    chk({tag, "_disp_label"}, 32'(disp_label), 32'(dl));
    chk({tag, "_iss_valid"},  32'(iss_valid),  32'(iv));
    chk({tag, "_iss_label"},  32'(iss_label),  32'(il));
    chk({tag, "_iss_op"},     32'(iss_op),     32'(eop));
    chk({tag, "_iss_v1"},     iss_v1,          32'(ev1));
    chk({tag, "_iss_v2"},     iss_v2,          32'(ev2));
  endtask

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_op = 0; disp_v1 = 0; disp_v2 = 0;
    disp_q1 = 0; disp_q2 = 0; bc_valid = 0; bc_label = 0; bc_data = 0; iss_ready = 0;
  endtask

  initial begin
    // Labels are {2'b01, idx}: entry 0..3 -> 4..7. Expected values are sampled after the edge.
    //          dv op v1  v2  q1 q2 bv bl bd     ir fl | cnt dr dl iv il op ev1    ev2
    vt[0]  = mk(1, 1, 10, 20, 0, 0, 0, 0, 0,     0, 0,   1,  1, 5, 1, 4, 1, 10,    20);
    vt[1]  = mk(1, 2, 11, 21, 0, 0, 0, 0, 0,     0, 0,   2,  1, 6, 1, 4, 1, 10,    20);
    vt[2]  = mk(1, 3, 12, 22, 0, 0, 0, 0, 0,     0, 0,   3,  1, 7, 1, 4, 1, 10,    20);
    vt[3]  = mk(1, 0, 13, 23, 0, 0, 0, 0, 0,     0, 0,   4,  0, 4, 1, 4, 1, 10,    20);
    vt[4]  = mk(1, 1, 99, 99, 0, 0, 0, 0, 0,     0, 0,   4,  0, 4, 1, 4, 1, 10,    20);
    // Full: the issue frees entry 0, but the dispatch in that same cycle is refused.
    vt[5]  = mk(1, 2, 30, 40, 0, 0, 0, 0, 0,     1, 0,   3,  1, 4, 1, 5, 2, 11,    21);
    // Dispatch and issue together: count holds, new entry lands in idx 0 as the youngest.
    vt[6]  = mk(1, 3, 31, 41, 0, 0, 0, 0, 0,     1, 0,   3,  1, 5, 1, 6, 3, 12,    22);
    vt[7]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,     1, 0,   2,  1, 5, 1, 7, 0, 13,    23);
    vt[8]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,     1, 0,   1,  1, 5, 1, 4, 3, 31,    41);
    vt[9]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,     1, 0,   0,  1, 4, 0, 0, 0, 0,     0);
    // A waits on tag 6, B ready; broadcast wakes A while B issues.
    vt[10] = mk(1, 1, 0,  7,  6, 0, 0, 0, 0,     0, 0,   1,  1, 5, 0, 0, 0, 0,     0);
    vt[11] = mk(1, 2, 8,  9,  0, 0, 0, 0, 0,     0, 0,   2,  1, 6, 1, 5, 2, 8,     9);
    vt[12] = mk(0, 0, 0,  0,  0, 0, 1, 6, 'h55,  1, 0,   1,  1, 5, 1, 4, 1, 'h55,  7);
    vt[13] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,     1, 0,   0,  1, 4, 0, 0, 0, 0,     0);
    // Dispatch bypass on q2, then a label-0 broadcast that must not touch ready entries.
    vt[14] = mk(1, 3, 1,  2,  0, 5, 1, 5, 'hAA,  0, 0,   1,  1, 5, 1, 4, 3, 1,     'hAA);
    vt[15] = mk(1, 1, 3,  4,  7, 0, 1, 0, 'hEE,  0, 0,   2,  1, 6, 1, 4, 3, 1,     'hAA);
    vt[16] = mk(0, 0, 0,  0,  0, 0, 1, 7, 'h77,  1, 0,   1,  1, 4, 1, 5, 1, 'h77,  4);
    vt[17] = mk(1, 2, 5,  6,  0, 0, 0, 0, 0,     0, 0,   2,  1, 6, 1, 5, 1, 'h77,  4);
    vt[18] = mk(1, 3, 7,  8,  0, 0, 0, 0, 0,     0, 0,   3,  1, 7, 1, 5, 1, 'h77,  4);
    // Flush beats the dispatch and the issue presented in the same cycle.
    vt[19] = mk(1, 1, 9,  9,  0, 0, 0, 0, 0,     1, 1,   0,  1, 4, 0, 0, 0, 0,     0);
    vt[20] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,     1, 0,   0,  1, 4, 0, 0, 0, 0,     0);

    idle_inputs();
    RST = 1;
    #2;
    chk_outs("reset", 0, 1, 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    RST = 0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      disp_valid = vt[i].dv; disp_op = vt[i].op; disp_v1 = vt[i].v1; disp_v2 = vt[i].v2;
      disp_q1 = vt[i].q1; disp_q2 = vt[i].q2; bc_valid = vt[i].bv; bc_label = vt[i].bl;
      bc_data = vt[i].bd; iss_ready = vt[i].ir; flush = vt[i].fl;
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), int'(vt[i].e_cnt), int'(vt[i].e_dr), int'(vt[i].e_dl),
               int'(vt[i].e_iv), int'(vt[i].e_il), int'(vt[i].e_op), int'(vt[i].e_v1),
               int'(vt[i].e_v2));
    end

    // Asynchronous reset with two entries busy, checked before any further clock edge.
    @(negedge clk);
    idle_inputs();
    disp_valid = 1; disp_op = 1; disp_v1 = 'h21; disp_v2 = 'h22;
    @(negedge clk);
    disp_op = 2; disp_v1 = 'h31; disp_v2 = 'h32;
    @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    @(negedge clk);
    idle_inputs();
    #2;
    RST = 1;
    #1;
    chk_outs("async_rst", 0, 1, 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    RST = 0;
    disp_valid = 1; disp_op = 3; disp_v1 = 'h33; disp_v2 = 'h44;
    @(posedge clk);
    #1;
    chk_outs("post_rst", 1, 1, 5, 1, 4, 3, 'h33, 'h44);
    @(negedge clk);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
